// File: rtl/axis_pkg.sv
// axis_pkg: helpers and reset constants shared by the axis stream blocks
package axis_pkg;
   localparam logic AXIS_TREADY_RST     = 1'b0;
   localparam logic AXIS_TVALID_RST     = 1'b0;
   localparam logic AXIS_PROG_FULL_RST  = 1'b0;
   localparam logic AXIS_PROG_EMPTY_RST = 1'b1;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int entry_width(input int dw);
      return dw + 1;
   endfunction
endpackage

// File: rtl/axis_fifo_pkt_ram.sv
// axis_fifo_pkt_ram: inferred simple dual-port RAM with registered read
module axis_fifo_pkt_ram
   import axis_pkg::*;
#(
   parameter int WIDTH = 73,
   parameter int DEPTH = 16,
   localparam int AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: single-clock AXI-stream FIFO with FWFT output register, thresholds and packet mode
module axis_fifo_pkt
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH        = 72,
   parameter int FIFO_DEPTH        = 16,
   parameter bit PACKET_MODE       = 1'b0,
   parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 2,
   parameter int PROG_EMPTY_THRESH = 2,
   localparam int AW = clog2(FIFO_DEPTH),
   localparam int EW = entry_width(DATA_WIDTH)
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst_n,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [AW:0]           fifo_count,
   output logic                  prog_full,
   output logic                  prog_empty
);
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
   logic [AW:0]   count, count_n, pkt_cnt, pkt_cnt_n;
   logic [EW-1:0] head, s_word, ram_q, ram_dout, fwd_data;
   logic          head_valid, bypass, bypass_n, fwd_valid, tready_r;
   logic          wr, rd, full, ram_empty, head_load, ram_pop, from_in, ram_we, head_last;
   always_comb begin
      s_word        = {s_axis_tlast, s_axis_tdata};
      head_last     = head[EW-1];
      full          = count == (AW+1)'(FIFO_DEPTH);
      s_axis_tready = tready_r;
      m_axis_tvalid = head_valid & (~PACKET_MODE | pkt_cnt != '0 | bypass);
      m_axis_tdata  = head[DATA_WIDTH-1:0];
      m_axis_tlast  = head_last;
      fifo_count    = count;
      wr            = s_axis_tvalid & tready_r;
      rd            = m_axis_tvalid & m_axis_tready;
      ram_empty     = count == (AW+1)'(head_valid);
      head_load     = ~head_valid | rd;
      ram_pop       = head_load & ~ram_empty;
      // with nothing queued behind the head, the incoming word skips the RAM
      from_in       = head_load & ram_empty & wr;
      ram_we        = wr & ~from_in;
      rd_ptr_n      = rd_ptr + AW'(ram_pop);
      ram_dout      = fwd_valid ? fwd_data : ram_q;
      count_n       = count + (AW+1)'(wr) - (AW+1)'(rd);
      pkt_cnt_n     = pkt_cnt + (AW+1)'(wr & s_axis_tlast) - (AW+1)'(rd & head_last);
      bypass_n      = (rd & head_last) ? 1'b0 : (bypass | (full & pkt_cnt == '0));
   end
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pkt_cnt    <= '0;
         bypass     <= 1'b0;
         head_valid <= AXIS_TVALID_RST;
         head       <= '0;
         fwd_valid  <= 1'b0;
         fwd_data   <= '0;
         tready_r   <= AXIS_TREADY_RST;
         prog_full  <= AXIS_PROG_FULL_RST;
         prog_empty <= AXIS_PROG_EMPTY_RST;
      end else begin
         if (ram_we) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_n;
         count   <= count_n;
         pkt_cnt <= pkt_cnt_n;
         bypass  <= bypass_n;
         if (head_load) head_valid <= ram_pop | from_in;
         if (ram_pop) head <= ram_dout;
         else if (from_in) head <= s_word;
         // read-before-write RAM misses a word written to the address being fetched
         fwd_valid  <= ram_we && wr_ptr == rd_ptr_n;
         fwd_data   <= s_word;
         tready_r   <= count_n != (AW+1)'(FIFO_DEPTH);
         prog_full  <= int'(count_n) >= PROG_FULL_THRESH;
         prog_empty <= int'(count_n) <= PROG_EMPTY_THRESH;
      end
   end
   axis_fifo_pkt_ram #(
      .WIDTH(EW),
      .DEPTH(1 << clog2(FIFO_DEPTH - 1))
   ) u_ram (
      .clk  (axis_clk),
      .we   (ram_we),
      .waddr(wr_ptr),
      .wdata(s_word),
      .raddr(rd_ptr_n),
      .rdata(ram_q)
   );
endmodule

// File: tb/tb_axis_fifo_pkt.sv
// tb_axis_fifo_pkt: scoreboard bench driving a streaming and a packet-mode FIFO with shared stimulus
module tb_axis_fifo_pkt;
   localparam int W = 72;
   localparam int D = 16;
   localparam int AW = 4;
   localparam int PFT0 = 14, PET0 = 2, PFT1 = 12, PET1 = 4;
   typedef logic [W:0] ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic s_tvalid [2];
   logic s_tlast, m_tready;
   logic [W-1:0] s_tdata;
   logic s_tready [2], m_tvalid [2], m_tlast [2], prog_full [2], prog_empty [2];
   logic [W-1:0] m_tdata [2];
   logic [AW:0] fifo_count [2];

   ent_t exp_q [2][$];
   int   pkts [2];
   bit   byp [2], up [2];
   int   total = 0, bad = 0, cyc = 0;

   always #5 clk = ~clk;

   axis_fifo_pkt #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .PACKET_MODE(1'b0),
                   .PROG_FULL_THRESH(PFT0), .PROG_EMPTY_THRESH(PET0)) dut0 (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[0]), .m_axis_tlast(m_tlast[0]),
      .fifo_count(fifo_count[0]), .prog_full(prog_full[0]), .prog_empty(prog_empty[0]));

   axis_fifo_pkt #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .PACKET_MODE(1'b1),
                   .PROG_FULL_THRESH(PFT1), .PROG_EMPTY_THRESH(PET1)) dut1 (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[1]), .m_axis_tlast(m_tlast[1]),
      .fifo_count(fifo_count[1]), .prog_full(prog_full[1]), .prog_empty(prog_empty[1]));

   task automatic chk(input int i, input string name, input logic [W:0] act, input logic [W:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
      end
   endtask

   task automatic chk_reset(input int i, input string tag);
      chk(i, {tag, "_tready"}, s_tready[i], 0);
      chk(i, {tag, "_tvalid"}, m_tvalid[i], 0);
      chk(i, {tag, "_tdata"}, m_tdata[i], 0);
      chk(i, {tag, "_tlast"}, m_tlast[i], 0);
      chk(i, {tag, "_count"}, fifo_count[i], 0);
      chk(i, {tag, "_pfull"}, prog_full[i], 0);
      chk(i, {tag, "_pempty"}, prog_empty[i], 1);
   endtask

   // monitor: compares every output against the reference queues, then applies this cycle's transfers
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         ent_t f;
         bit   ev, rd, wr;
         int   sz;
         if (!rst_n) begin
            chk_reset(i, "in_reset");
            exp_q[i].delete();
            pkts[i] = 0;
            byp[i]  = 0;
            up[i]   = 0;
         end else begin
            sz = exp_q[i].size();
            f  = sz != 0 ? exp_q[i][0] : '0;
            ev = sz != 0 && (i == 0 || pkts[i] > 0 || byp[i]);
            chk(i, "tready", s_tready[i], up[i] && sz != D);
            chk(i, "tvalid", m_tvalid[i], ev);
            chk(i, "count", fifo_count[i], sz);
            chk(i, "prog_full", prog_full[i], sz >= (i == 0 ? PFT0 : PFT1));
            chk(i, "prog_empty", prog_empty[i], sz <= (i == 0 ? PET0 : PET1));
            if (m_tvalid[i] === 1'b1 && sz != 0) chk(i, "data", {m_tlast[i], m_tdata[i]}, f);
            rd = m_tvalid[i] === 1'b1 && m_tready;
            wr = s_tvalid[i] && s_tready[i] === 1'b1;
            if (rd && f[W]) byp[i] = 0;
            else if (sz == D && pkts[i] == 0) byp[i] = 1;
            if (rd && sz != 0) begin
               void'(exp_q[i].pop_front());
               if (f[W]) pkts[i]--;
            end
            if (wr) begin
               exp_q[i].push_back({s_tlast, s_tdata});
               if (s_tlast) pkts[i]++;
            end
            up[i] = 1;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic l);
      int n;
      bit a0, a1;
      n = 0;
      s_tdata = d;
      s_tlast = l;
      s_tvalid[0] = 1'b1;
      s_tvalid[1] = 1'b1;
      while (s_tvalid[0] || s_tvalid[1]) begin
         @(negedge clk);
         a0 = s_tvalid[0] && s_tready[0] === 1'b1;
         a1 = s_tvalid[1] && s_tready[1] === 1'b1;
         @(posedge clk);
         #1;
         cyc++;
         n++;
         if (a0) s_tvalid[0] = 1'b0;
         if (a1) s_tvalid[1] = 1'b0;
         if (n >= 300 && (s_tvalid[0] || s_tvalid[1])) begin
            chk(0, "send_timeout", 1, 0);
            s_tvalid[0] = 1'b0;
            s_tvalid[1] = 1'b0;
         end
      end
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (n < 600 && (exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(0, "drain_left", exp_q[0].size() + exp_q[1].size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      s_tvalid[0] = 1'b0;
      s_tvalid[1] = 1'b0;
      s_tdata = '0;
      s_tlast = 1'b0;
      m_tready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // fill past capacity with the sink stalled, then drain in order
      for (int k = 0; k < 16; k++) send(W'(k), k == 15);
      s_tdata = W'(16);
      s_tlast = 1'b0;
      s_tvalid[0] = 1'b1;
      s_tvalid[1] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) chk(i, "full_tready", s_tready[i], 0);
      end
      s_tvalid[0] = 1'b0;
      s_tvalid[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk(i, "full_count", fifo_count[i], D);
         chk(i, "full_pfull", prog_full[i], 1);
      end
      @(posedge clk);
      #1 m_tready = 1'b1;
      wait_empty();
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk(i, "drained_pempty", prog_empty[i], 1);

      // hold full, then stream both sides
      @(posedge clk);
      #1 m_tready = 1'b0;
      for (int k = 0; k < 16; k++) send(W'(k + 100), (k % 4) == 3);
      m_tready = 1'b1;
      cyc = 0;
      for (int k = 16; k < 116; k++) send(W'(k + 100), (k % 4) == 3);
      chk(0, "stream_cycles", cyc, 101);
      wait_empty();

      // packet held until its tlast arrives, then released back to back
      for (int k = 0; k < 4; k++) send(W'(k + 500), 1'b0);
      idle(3);
      @(negedge clk);
      chk(1, "pkt_hold", m_tvalid[1], 0);
      @(posedge clk);
      #1 send(W'(504), 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk(1, "pkt_b2b", m_tvalid[1], 1);
      end
      wait_empty();

      // oversize packet forces bypass, which must drop after its tlast
      m_tready = 1'b0;
      for (int k = 0; k < 16; k++) send(W'(k + 700), 1'b0);
      m_tready = 1'b1;
      for (int k = 16; k < 20; k++) send(W'(k + 700), k == 19);
      wait_empty();
      for (int k = 0; k < 3; k++) send(W'(k + 800), 1'b0);
      idle(3);
      @(negedge clk);
      chk(1, "bypass_clear", m_tvalid[1], 0);
      @(posedge clk);
      #1 send(W'(803), 1'b1);
      wait_empty();

      // random traffic with random backpressure
      begin
         int sent, guard, pct;
         bit a0, a1;
         sent = 0;
         guard = 0;
         while (sent < 10000 && guard < 80000) begin
            pct = ((sent / 1000) % 3 == 0) ? 25 : ((sent / 1000) % 3 == 1) ? 60 : 95;
            if (!s_tvalid[0] && !s_tvalid[1] && $urandom_range(3) != 0) begin
               s_tdata = {8'(sent), 32'($urandom), 32'($urandom)};
               s_tlast = $urandom_range(7) == 0;
               s_tvalid[0] = 1'b1;
               s_tvalid[1] = 1'b1;
               sent++;
            end
            m_tready = $urandom_range(99) < pct;
            @(negedge clk);
            a0 = s_tvalid[0] && s_tready[0] === 1'b1;
            a1 = s_tvalid[1] && s_tready[1] === 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (a0) s_tvalid[0] = 1'b0;
            if (a1) s_tvalid[1] = 1'b0;
         end
         chk(0, "random_guard", guard >= 80000, 0);
         m_tready = 1'b1;
         guard = 0;
         while ((s_tvalid[0] || s_tvalid[1]) && guard < 300) begin
            @(negedge clk);
            a0 = s_tvalid[0] && s_tready[0] === 1'b1;
            a1 = s_tvalid[1] && s_tready[1] === 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (a0) s_tvalid[0] = 1'b0;
            if (a1) s_tvalid[1] = 1'b0;
         end
         send(W'(999), 1'b1);
         wait_empty();
      end

      // asynchronous reset in the middle of a packet
      m_tready = 1'b0;
      for (int k = 0; k < 7; k++) send(W'(k + 1200), 1'b0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk(i, "pre_reset_count", fifo_count[i], 7);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) chk_reset(i, "async_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_tready = 1'b1;
      for (int k = 0; k < 3; k++) send(W'(k + 1300), k == 2);
      wait_empty();
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
